// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: two-requester round-robin arbiter driving a single APB master port with wait-state timeout.
module gpio_apb_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [1:0]  gnt,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, COMPLETE} state_e;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic last_q, last_d, psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic win, tout;
    logic [31:0] addr_w, rd;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        last_d = last_q;
        gnt_d = gnt_q;
        psel_d = 1'b0;
        penable_d = 1'b0;
        pwrite_d = pwrite_q;
        paddr_d = paddr_q;
        pwdata_d = pwdata_q;
        done_d = 2'b00;
        err_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        win = (m0_req && m1_req) ? !last_q : m1_req;
        addr_w = win ? m1_addr : m0_addr;
        rd = pwrite_q ? 32'h0 : prdata;
        tout = (TIMEOUT != 0) && (cnt_q == TLAST);
        unique case (state_q)
            IDLE: begin
                gnt_d = 2'b00;
                if (m0_req || m1_req) begin
                    state_d = SETUP;
                    last_d = win;
                    gnt_d = win ? 2'b10 : 2'b01;
                    psel_d = 1'b1;
                    cnt_d = '0;
                    pwrite_d = win ? m1_write : m0_write;
                    paddr_d = {addr_w[31:2], 2'b00};
                    pwdata_d = win ? m1_wdata : m0_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                psel_d = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready || tout) begin
                    // A timed-out transfer reports zero read data.
                    state_d = COMPLETE;
                    done_d = gnt_q;
                    err_d = gnt_q & {2{!pready}};
                    rdata0_d = gnt_q[0] ? (pready ? rd : 32'h0) : rdata0_q;
                    rdata1_d = gnt_q[1] ? (pready ? rd : 32'h0) : rdata1_q;
                end else begin
                    psel_d = 1'b1;
                    penable_d = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COMPLETE: begin
                state_d = IDLE;
                gnt_d = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            last_q <= 1'b1;
            gnt_q <= 2'b00;
            psel_q <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q <= 32'h0;
            pwdata_q <= 32'h0;
            done_q <= 2'b00;
            err_q <= 2'b00;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            last_q <= last_d;
            gnt_q <= gnt_d;
            psel_q <= psel_d;
            penable_q <= penable_d;
            pwrite_q <= pwrite_d;
            paddr_q <= paddr_d;
            pwdata_q <= pwdata_d;
            done_q <= done_d;
            err_q <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end
    assign gnt = gnt_q;
    assign psel = psel_q;
    assign penable = penable_q;
    assign pwrite = pwrite_q;
    assign paddr = paddr_q;
    assign pwdata = pwdata_q;
    assign m0_done = done_q[0];
    assign m1_done = done_q[1];
    assign m0_err = err_q[0];
    assign m1_err = err_q[1];
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// tb_gpio_apb_arbiter: randomized transactions checked against a transaction-level model of the arbiter.
module tb_gpio_apb_arbiter;
    localparam int TO = 16;
    logic pclk = 1'b0, preset = 1'b1;
    logic m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic m0_done, m0_err, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0] gnt;
    logic psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;
    logic pready = 1'b0;
    int n_chk = 0, n_err = 0;
    bit last_m = 1'b1;
    logic [31:0] exp_rd [2];
    logic wr [2];
    logic [31:0] ad [2], wd [2], prd;
    always #5 pclk = ~pclk;
    gpio_apb_arbiter #(.TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .gnt(gnt), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic rand_ops();
        for (int i = 0; i < 2; i++) begin
            wr[i] = 1'($urandom_range(0, 1));
            ad[i] = $urandom;
            wd[i] = $urandom;
        end
        prd = $urandom;
    endtask
    // One arbitrated transfer; waits >= TO means pready never rises.
    task automatic txn(input bit r0, input bit r1, input int waits);
        int w, acc;
        logic [31:0] exp_r, amask;
        @(negedge pclk);
        m0_write = wr[0]; m0_addr = ad[0]; m0_wdata = wd[0];
        m1_write = wr[1]; m1_addr = ad[1]; m1_wdata = wd[1];
        m0_req = r0; m1_req = r1; pready = 1'b0; prdata = prd;
        w = (r0 && r1) ? int'(!last_m) : int'(r1);
        last_m = (w == 1);
        amask = ad[w] & 32'hFFFF_FFFC;
        @(posedge pclk);
        @(negedge pclk);
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_gnt", 32'(gnt), w == 1 ? 32'd2 : 32'd1);
        chk("setup_paddr", paddr, amask);
        chk("setup_pwrite", 32'(pwrite), 32'(wr[w]));
        chk("setup_pwdata", pwdata, wd[w]);
        m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
        acc = waits < TO ? waits + 1 : TO;
        for (int k = 0; k < acc; k++) begin
            @(posedge pclk);
            @(negedge pclk);
            chk("access_ctl", {30'd0, psel, penable}, 32'd3);
            chk("access_gnt", 32'(gnt), w == 1 ? 32'd2 : 32'd1);
            chk("access_paddr", paddr, amask);
            chk("access_done", {30'd0, m1_done, m0_done}, 32'd0);
            pready = (k == waits);
        end
        @(posedge pclk);
        @(negedge pclk);
        pready = 1'b0;
        exp_r = (waits >= TO || wr[w]) ? 32'h0 : prd;
        exp_rd[w] = exp_r;
        chk("cpl_done", {30'd0, m1_done, m0_done}, w == 1 ? 32'd2 : 32'd1);
        chk("cpl_err", {30'd0, m1_err, m0_err}, waits >= TO ? (w == 1 ? 32'd2 : 32'd1) : 32'd0);
        chk("cpl_rdata0", m0_rdata, exp_rd[0]);
        chk("cpl_rdata1", m1_rdata, exp_rd[1]);
        chk("cpl_ctl", {30'd0, psel, penable}, 32'd0);
        @(posedge pclk);
        @(negedge pclk);
        chk("idle_done", {30'd0, m1_done, m0_done}, 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_rdata0", m0_rdata, exp_rd[0]);
        chk("idle_rdata1", m1_rdata, exp_rd[1]);
    endtask
    initial begin
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_ctl", {27'd0, psel, penable, pwrite, gnt}, 32'd0);
        chk("rst_bus", paddr | pwdata, 32'd0);
        chk("rst_done", {28'd0, m1_done, m0_done, m1_err, m0_err}, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        preset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            txn(1'b1, 1'b1, int'($urandom_range(0, 3)));
        end
        wr[0] = 1'b1; ad[0] = 32'h8; wd[0] = 32'hFFFF_0000;
        txn(1'b1, 1'b0, 0);
        rand_ops();
        wr[1] = 1'b0; ad[1] = 32'h4; prd = 32'hA5A5_A5A5;
        txn(1'b0, 1'b1, 2);
        rand_ops();
        wr[0] = 1'b0; ad[0] = 32'hE;
        txn(1'b1, 1'b0, 0);
        rand_ops();
        wr[0] = 1'b0;
        txn(1'b1, 1'b0, 20);
        rand_ops();
        txn(1'b1, 1'b0, 1);
        for (int i = 0; i < 40; i++) begin
            int v;
            rand_ops();
            v = int'($urandom_range(1, 3));
            txn(v[0], v[1], ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4)));
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end
        rand_ops();
        @(negedge pclk);
        m0_req = 1'b1; m0_write = wr[0]; m0_addr = ad[0]; m0_wdata = wd[0];
        @(posedge pclk);
        @(negedge pclk);
        m0_req = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk("pre_rst_access", {30'd0, psel, penable}, 32'd3);
        preset = 1'b1;
        @(posedge pclk);
        #1;
        chk("mid_rst_ctl", {28'd0, psel, penable, gnt}, 32'd0);
        chk("mid_rst_done", {30'd0, m1_done, m0_done}, 32'd0);
        @(negedge pclk);
        preset = 1'b0;
        last_m = 1'b1;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        @(negedge pclk);
        chk("post_rst_idle", {28'd0, psel, penable, m1_done, m0_done}, 32'd0);
        rand_ops();
        txn(1'b1, 1'b1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
